// File: rtl/regfile_checker_if.sv
// Bundle of control, read-port and result signals between the register-file
// checker (master) and the environment that owns the two memories (slave).
interface regfile_checker_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_W     = 5
);
  logic                  start;
  logic                  abort;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_WIDTH-1:0] rf_rd_data;
  logic [DATA_WIDTH-1:0] exp_rd_data;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [ADDR_W:0]       match_cnt;
  logic                  err_valid;
  logic [ADDR_W-1:0]     err_idx;
  logic [DATA_WIDTH-1:0] err_got;
  logic [DATA_WIDTH-1:0] err_exp;

  modport master (
    input  start, abort, rf_rd_data, exp_rd_data,
    output rd_en, rd_addr, busy, done, pass, match_cnt,
           err_valid, err_idx, err_got, err_exp
  );

  modport slave (
    output start, abort, rf_rd_data, exp_rd_data,
    input  rd_en, rd_addr, busy, done, pass, match_cnt,
           err_valid, err_idx, err_got, err_exp
  );
endinterface

// File: rtl/regfile_checker.sv
// Scans a register file against an expected-value memory after a settle delay,
// counting matches and capturing the lowest mismatching index and its values.
module regfile_checker #(
  parameter int                     DATA_WIDTH    = 64,
  parameter int                     NUM_REGS      = 32,
  parameter int                     ADDR_W        = 5,
  parameter int                     SETTLE_CYCLES = 50,
  parameter logic [NUM_REGS-1:0]    CHECK_MASK    = '1
) (
  input  logic               clk,
  input  logic               rst,
  regfile_checker_if.master  bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]       SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0]      LAST_ADDR   = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]        FULL_CNT    = (ADDR_W+1)'(NUM_REGS);
  localparam logic [2**ADDR_W-1:0]   MASK_EXT    = (2**ADDR_W)'(CHECK_MASK);

  typedef enum logic [2:0] {IDLE, SETTLE, SCAN, DRAIN, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  settle_cnt;
  logic              cmp_pending;   // read data for cmp_idx is on the bus this cycle
  logic [ADDR_W-1:0] cmp_idx;
  logic              is_match;
  logic              do_cmp;
  logic [ADDR_W:0]   cnt_next;

  always_comb begin
    is_match = (bus.rf_rd_data == bus.exp_rd_data) || !MASK_EXT[cmp_idx];
    do_cmp   = cmp_pending && !bus.abort;
    cnt_next = bus.match_cnt + (ADDR_W+1)'(is_match);
  end

  // NOTE: all state and outputs use non-blocking assignments so every branch
  // below sees the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      cmp_pending   <= 1'b0;
      cmp_idx       <= '0;
      bus.rd_en     <= 1'b0;
      bus.rd_addr   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.match_cnt <= '0;
      bus.err_valid <= 1'b0;
      bus.err_idx   <= '0;
      bus.err_got   <= '0;
      bus.err_exp   <= '0;
    end else begin
      if (do_cmp) begin
        if (is_match) begin
          bus.match_cnt <= cnt_next;
        end else if (!bus.err_valid) begin
          bus.err_valid <= 1'b1;
          bus.err_idx   <= cmp_idx;
          bus.err_got   <= bus.rf_rd_data;
          bus.err_exp   <= bus.exp_rd_data;
        end
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy      <= 1'b1;
            bus.pass      <= 1'b0;
            bus.match_cnt <= '0;
            bus.err_valid <= 1'b0;
            bus.err_idx   <= '0;
            bus.err_got   <= '0;
            bus.err_exp   <= '0;
            cmp_pending   <= 1'b0;
            settle_cnt    <= '0;
            if (SETTLE_CYCLES == 0) begin
              state       <= SCAN;
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= '0;
            end else begin
              state       <= SETTLE;
            end
          end
        end

        SETTLE, SCAN, DRAIN: begin
          if (bus.abort) begin
            state       <= IDLE;
            bus.busy    <= 1'b0;
            bus.rd_en   <= 1'b0;
            bus.rd_addr <= '0;
            bus.pass    <= 1'b0;
            cmp_pending <= 1'b0;
          end else if (state == SETTLE) begin
            if (settle_cnt == SETTLE_LAST) begin
              state       <= SCAN;
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= '0;
            end else begin
              settle_cnt  <= settle_cnt + 1'b1;
            end
          end else if (state == SCAN) begin
            cmp_pending <= 1'b1;
            cmp_idx     <= bus.rd_addr;
            if (bus.rd_addr == LAST_ADDR) begin
              state       <= DRAIN;
              bus.rd_en   <= 1'b0;
              bus.rd_addr <= '0;
            end else begin
              bus.rd_addr <= bus.rd_addr + 1'b1;
            end
          end else begin
            // Final comparison lands this cycle, so pass folds it in directly.
            cmp_pending <= 1'b0;
            state       <= DONE;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.pass    <= ((is_match ? cnt_next : bus.match_cnt) == FULL_CNT);
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_checker.sv
// Directed and randomized checks of regfile_checker against a cycle-formula and
// array-scan reference model, across three parameterizations.
module tb_regfile_checker;
  localparam int DW = 64;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam logic [NR-1:0] MASK_B = 32'hFFFF_FF7F;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_checker_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus_a ();
  regfile_checker_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus_b ();
  regfile_checker_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus_c ();

  int   sel;
  logic start_r, abort_r;
  assign bus_a.start = start_r && (sel == 0);
  assign bus_b.start = start_r && (sel == 1);
  assign bus_c.start = start_r && (sel == 2);
  assign bus_a.abort = abort_r && (sel == 0);
  assign bus_b.abort = abort_r && (sel == 1);
  assign bus_c.abort = abort_r && (sel == 2);

  regfile_checker #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_W(AW), .SETTLE_CYCLES(4), .CHECK_MASK('1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  regfile_checker #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_W(AW), .SETTLE_CYCLES(4), .CHECK_MASK(MASK_B))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  regfile_checker #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_W(AW), .SETTLE_CYCLES(0), .CHECK_MASK('1))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  // Memory models: one-cycle read latency, garbage when not being read.
  logic [DW-1:0] rf_mem  [NR];
  logic [DW-1:0] exp_mem [NR];
  always @(posedge clk) begin
    bus_a.rf_rd_data  <= bus_a.rd_en ? rf_mem[bus_a.rd_addr]  : {$urandom, $urandom};
    bus_a.exp_rd_data <= bus_a.rd_en ? exp_mem[bus_a.rd_addr] : {$urandom, $urandom};
    bus_b.rf_rd_data  <= bus_b.rd_en ? rf_mem[bus_b.rd_addr]  : {$urandom, $urandom};
    bus_b.exp_rd_data <= bus_b.rd_en ? exp_mem[bus_b.rd_addr] : {$urandom, $urandom};
    bus_c.rf_rd_data  <= bus_c.rd_en ? rf_mem[bus_c.rd_addr]  : {$urandom, $urandom};
    bus_c.exp_rd_data <= bus_c.rd_en ? exp_mem[bus_c.rd_addr] : {$urandom, $urandom};
  end

  logic          o_rd_en, o_busy, o_done, o_pass, o_err_valid;
  logic [AW-1:0] o_rd_addr, o_err_idx;
  logic [AW:0]   o_match_cnt;
  logic [DW-1:0] o_err_got, o_err_exp;
  always_comb begin
    {o_rd_en, o_rd_addr, o_busy, o_done, o_pass, o_match_cnt, o_err_valid, o_err_idx, o_err_got, o_err_exp} =
      {bus_a.rd_en, bus_a.rd_addr, bus_a.busy, bus_a.done, bus_a.pass, bus_a.match_cnt,
       bus_a.err_valid, bus_a.err_idx, bus_a.err_got, bus_a.err_exp};
    if (sel == 1)
      {o_rd_en, o_rd_addr, o_busy, o_done, o_pass, o_match_cnt, o_err_valid, o_err_idx, o_err_got, o_err_exp} =
        {bus_b.rd_en, bus_b.rd_addr, bus_b.busy, bus_b.done, bus_b.pass, bus_b.match_cnt,
         bus_b.err_valid, bus_b.err_idx, bus_b.err_got, bus_b.err_exp};
    else if (sel == 2)
      {o_rd_en, o_rd_addr, o_busy, o_done, o_pass, o_match_cnt, o_err_valid, o_err_idx, o_err_got, o_err_exp} =
        {bus_c.rd_en, bus_c.rd_addr, bus_c.busy, bus_c.done, bus_c.pass, bus_c.match_cnt,
         bus_c.err_valid, bus_c.err_idx, bus_c.err_got, bus_c.err_exp};
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " rd_en"},     o_rd_en, 0);
    check({tag, " rd_addr"},   o_rd_addr, 0);
    check({tag, " busy"},      o_busy, 0);
    check({tag, " done"},      o_done, 0);
    check({tag, " pass"},      o_pass, 0);
    check({tag, " match_cnt"}, o_match_cnt, 0);
    check({tag, " err_valid"}, o_err_valid, 0);
    check({tag, " err_idx"},   o_err_idx, 0);
    check({tag, " err_got"},   o_err_got, 0);
    check({tag, " err_exp"},   o_err_exp, 0);
  endtask

  // Reference: scan the arrays in index order under the instance's mask.
  task automatic check_results(input string tag);
    int            cnt = 0;
    int            first = -1;
    logic          m;
    for (int i = 0; i < NR; i++) begin
      m = (rf_mem[i] == exp_mem[i]) || (sel == 1 && !MASK_B[i]);
      if (m) cnt++;
      else if (first < 0) first = i;
    end
    check({tag, " pass"},      o_pass, (cnt == NR));
    check({tag, " match_cnt"}, o_match_cnt, cnt);
    check({tag, " err_valid"}, o_err_valid, (first >= 0));
    if (first >= 0) begin
      check({tag, " err_idx"}, o_err_idx, first);
      check({tag, " err_got"}, o_err_got, rf_mem[first]);
      check({tag, " err_exp"}, o_err_exp, exp_mem[first]);
    end
  endtask

  // Start a run and check the per-cycle trace; optionally pulse start again
  // in cycle restart_at, which must be ignored.
  task automatic run(input string tag, input int restart_at);
    int   t = (sel == 2) ? 0 : 4;
    logic exp_en;
    int   exp_addr;
    @(posedge clk); #1 start_r = 1'b1;
    @(posedge clk); #1 start_r = 1'b0;
    for (int c = 0; c <= t + NR + 2; c++) begin
      @(negedge clk);
      exp_en   = (c >= t) && (c < t + NR);
      exp_addr = exp_en ? c - t : 0;
      check($sformatf("%s trace c%0d", tag, c), {o_rd_en, o_rd_addr, o_busy, o_done},
            {exp_en, AW'(exp_addr), 1'(c <= t + NR), 1'(c == t + NR + 1)});
      start_r = (c == restart_at);
    end
    start_r = 1'b0;
    check_results(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start_r = 1'b0; abort_r = 1'b0; sel = 0;
    for (int i = 0; i < NR; i++) begin
      rf_mem[i]  = {$urandom, $urandom};
      exp_mem[i] = rf_mem[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1 rst = 1'b0;

    // All registers equal.
    run("equal", -1);

    // Mismatches at 7 and 20; a start in the DONE cycle is ignored.
    rf_mem[7]   = 64'h5;
    exp_mem[7]  = 64'h6;
    exp_mem[20] = rf_mem[20] ^ 64'h1;
    run("mism", 4 + NR + 1);
    check("mism const cnt", o_match_cnt, 30);
    check("mism const idx", o_err_idx, 7);
    check("mism const got", o_err_got, 64'h5);
    check("mism const exp", o_err_exp, 64'h6);

    // Same data with register 7 masked off.
    sel = 1;
    run("masked", -1);
    check("masked const cnt", o_match_cnt, 31);
    check("masked const idx", o_err_idx, 20);

    // Randomized contents with sparse mismatches.
    sel = 0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NR; i++) begin
        rf_mem[i]  = {$urandom, $urandom};
        exp_mem[i] = ($urandom_range(3) == 0) ? {$urandom, $urandom} : rf_mem[i];
      end
      run($sformatf("rand%0d", r), -1);
    end

    // Abort in cycle 10, restart in cycle 12, ignored start during new run.
    @(posedge clk); #1 start_r = 1'b1;
    @(posedge clk); #1 start_r = 1'b0;
    repeat (10) @(posedge clk);
    #1 abort_r = 1'b1;
    @(negedge clk);
    check("abort c10 busy", o_busy, 1);
    @(posedge clk); #1 abort_r = 1'b0;
    @(negedge clk);
    check("abort c11 state", {o_busy, o_done, o_pass, o_rd_en}, 4'b0000);
    run("restart", 7);

    // Asynchronous reset in cycle 15 of a run.
    @(posedge clk); #1 start_r = 1'b1;
    @(posedge clk); #1 start_r = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset("midrun reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check($sformatf("post reset idle c%0d", c), {o_busy, o_done, o_rd_en}, 3'b000);
    end

    // Zero settle time.
    sel = 2;
    for (int i = 0; i < NR; i++) exp_mem[i] = rf_mem[i];
    run("settle0", -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
